// File: rtl/ram_arbiter.sv
// Two-core shared RAM port arbiter: data-over-instruction priority, round-robin
// between cores, fixed-length data bursts and age-based instruction promotion.
module ram_arbiter #(
    parameter int BURST   = 2,
    parameter int AGE_MAX = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    output logic [1:0]       iwait,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] iload,
    output logic [1:0][31:0] dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic       KIND_I     = 1'b0;
    localparam logic       KIND_D     = 1'b1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] WLAST      = 2'(BURST - 1);
    localparam logic [3:0] AGE_SAT    = 4'(AGE_MAX);

    state_t          state_q, state_d;
    logic            gcore_q, gcore_d;
    logic            gkind_q, gkind_d;
    logic            last_q, last_d;
    logic [1:0]      wcnt_q, wcnt_d;
    logic [1:0][3:0] age_q, age_d;

    logic       live;
    logic       any_req;
    logic       pick_core;
    logic       pick_kind;
    logic [1:0] promo;
    logic [1:0] dreq;

    // Tie between both cores goes to the one that was not granted last.
    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    assign iload = {ramload, ramload};
    assign dload = {ramload, ramload};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            promo[c] = iREN[c] && (age_q[c] == AGE_SAT);
        end
        dreq      = dREN | dWEN;
        any_req   = |{iREN, dreq};
        pick_kind = KIND_I;
        pick_core = pick(iREN, last_q);
        if (|promo) begin
            pick_core = pick(promo, last_q);
        end else if (|dreq) begin
            pick_kind = KIND_D;
            pick_core = pick(dreq, last_q);
        end
    end

    // RAM drive comes from the granted requester's live inputs; no ramstate here.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        live     = 1'b0;
        if (state_q == GRANT) begin
            if (gkind_q == KIND_I) begin
                live = iREN[gcore_q];
                if (live) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[gcore_q];
                end
            end else begin
                live = dREN[gcore_q] | dWEN[gcore_q];
                if (dWEN[gcore_q]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[gcore_q];
                    ramstore = dstore[gcore_q];
                end else if (dREN[gcore_q]) begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[gcore_q];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gcore_d = gcore_q;
        gkind_d = gkind_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        iwait   = 2'b11;
        dwait   = 2'b11;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    gcore_d = pick_core;
                    gkind_d = pick_kind;
                    last_d  = pick_core;
                    wcnt_d  = 2'd0;
                end
            end
            GRANT: begin
                if (!live) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    if (gkind_q == KIND_I) begin
                        iwait[gcore_q] = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        dwait[gcore_q] = 1'b0;
                        if (wcnt_q == WLAST) state_d = IDLE;
                        else                 wcnt_d  = wcnt_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An instruction counts as granted both when picked and while being served.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            if (!iREN[c]
                || (state_q == IDLE && any_req && pick_kind == KIND_I && pick_core == 1'(c))
                || (state_q == GRANT && gkind_q == KIND_I && gcore_q == 1'(c))) begin
                age_d[c] = 4'd0;
            end else if (age_q[c] != AGE_SAT) begin
                age_d[c] = age_q[c] + 4'd1;
            end else begin
                age_d[c] = age_q[c];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gcore_q <= 1'b0;
            gkind_q <= KIND_I;
            last_q  <= 1'b1;
            wcnt_q  <= 2'd0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            gcore_q <= gcore_d;
            gkind_q <= gkind_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a latency-programmable RAM model, a completion
// scoreboard fed by the stimulus, and a negedge monitor that pops and compares.
module tb_ram_arbiter;

    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    always #5 CLK = ~CLK;

    ram_arbiter #(.BURST(2), .AGE_MAX(15)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    // RAM model: ACCESS on the lat-th enabled cycle of each word, ERROR when forced.
    int   lat = 2;
    bit   err = 1'b0;
    int   cnt = 0;
    logic ram_en;
    assign ram_en  = ramREN | ramWEN;
    assign ramload = ramaddr ^ 32'hA5A5_0000;

    always_comb begin
        if (!ram_en)            ramstate = 2'd0;
        else if (err)           ramstate = 2'd3;
        else if (cnt >= lat - 1) ramstate = 2'd2;
        else                    ramstate = 2'd1;
    end

    always @(posedge CLK) begin
        if (!ram_en || ramstate == 2'd2) cnt <= 0;
        else if (ramstate == 2'd1)       cnt <= cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;   // 0=I0 1=D0 2=I1 3=D1
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] addr, input logic [31:0] data,
                        input logic wr);
        exp_t e;
        e.id = id; e.addr = addr; e.data = data; e.wr = wr;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Returns at the negedge where the requester's wait is low; cyc counts from now.
    task automatic wait_low(input int id, input int max, output int cyc);
        logic lo;
        for (cyc = 0; cyc < max; cyc++) begin
            @(negedge CLK);
            lo = (id % 2 == 1) ? !dwait[id/2] : !iwait[id/2];
            if (lo) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_req%0d: no completion within %0d cycles", id, max);
    endtask

    int   mon_n, mon_id;
    exp_t mon_e;
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            mon_n  = 0;
            mon_id = 0;
            for (int c = 0; c < 2; c++) begin
                if (!iwait[c]) begin mon_n++; mon_id = 2*c;     end
                if (!dwait[c]) begin mon_n++; mon_id = 2*c + 1; end
            end
            if (mon_n > 1) chk("single_wait_low", mon_n, 1);
            if (mon_n >= 1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: req%0d addr %h, none required",
                             mon_id, ramaddr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_requester", mon_id, mon_e.id);
                    chk("sb_addr", ramaddr, mon_e.addr);
                    if (mon_e.wr) begin
                        chk("sb_wen", 32'(ramWEN), 32'd1);
                        chk("sb_store", ramstore, mon_e.data);
                    end else begin
                        chk("sb_ren", 32'(ramREN), 32'd1);
                        chk("sb_load", (mon_id % 2 == 1) ? dload[mon_id/2] : iload[mon_id/2],
                            mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2;
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;

        // Reset with a pending instruction fetch, L=2
        lat = 2;
        iREN[0] = 1'b1;
        iaddr[0] = 32'h0000_0040;
        @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_dwait", 32'(dwait), 32'h3);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        push(0, 32'h0000_0040, 32'hA5A5_0040, 1'b0);
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ramREN", 32'(ramREN), 32'd0);
        chk("idle_ramaddr", ramaddr, 32'd0);
        step();
        @(negedge CLK);
        chk("first_grant_ramREN", 32'(ramREN), 32'd1);
        chk("first_grant_addr", ramaddr, 32'h0000_0040);
        wait_low(0, 10, c);
        chk("i0_done_cycle", c + 2, 32'd2);
        step();
        iREN[0] = 1'b0;

        // Data block read, L=2
        step();
        push(1, 32'h0000_0100, 32'hA5A5_0100, 1'b0);
        push(1, 32'h0000_0104, 32'hA5A5_0104, 1'b0);
        daddr[0] = 32'h0000_0100;
        dREN[0] = 1'b1;
        wait_low(1, 20, c);
        chk("blk_word0_cycle", c, 32'd2);
        step();
        daddr[0] = 32'h0000_0104;
        wait_low(1, 20, c2);
        chk("blk_word1_cycle", 3 + c2, 32'd4);
        step();
        dREN[0] = 1'b0;
        @(negedge CLK);
        chk("blk_back_idle", 32'({ramREN, ramWEN}), 32'd0);

        // Priority and round-robin from reset: D0 block, D1 block, then I0
        RST = 1'b1;
        lat = 1;
        dREN = 2'b11;
        iREN[0] = 1'b1;
        daddr[0] = 32'h0000_0200;
        daddr[1] = 32'h0000_0300;
        iaddr[0] = 32'h0000_0080;
        push(1, 32'h0000_0200, 32'hA5A5_0200, 1'b0);
        push(1, 32'h0000_0204, 32'hA5A5_0204, 1'b0);
        push(3, 32'h0000_0300, 32'hA5A5_0300, 1'b0);
        push(3, 32'h0000_0304, 32'hA5A5_0304, 1'b0);
        push(0, 32'h0000_0080, 32'hA5A5_0080, 1'b0);
        step();
        RST = 1'b0;
        wait_low(1, 20, c);
        step(); daddr[0] = 32'h0000_0204;
        wait_low(1, 20, c);
        step(); dREN[0] = 1'b0;
        wait_low(3, 20, c);
        step(); daddr[1] = 32'h0000_0304;
        wait_low(3, 20, c);
        step(); dREN[1] = 1'b0;
        wait_low(0, 20, c);
        step(); iREN[0] = 1'b0;

        // Starvation: continuous data from both cores, I1 must be promoted
        @(negedge CLK);
        RST = 1'b1;
        lat = 1;
        dREN = 2'b11;
        iREN[1] = 1'b1;
        daddr[0] = 32'h0000_0500;
        daddr[1] = 32'h0000_0600;
        iaddr[1] = 32'h0000_0700;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                push(1, 32'h0000_0500, 32'hA5A5_0500, 1'b0);
                push(1, 32'h0000_0500, 32'hA5A5_0500, 1'b0);
            end else begin
                push(3, 32'h0000_0600, 32'hA5A5_0600, 1'b0);
                push(3, 32'h0000_0600, 32'hA5A5_0600, 1'b0);
            end
        end
        push(2, 32'h0000_0700, 32'hA5A5_0700, 1'b0);
        step();
        RST = 1'b0;
        wait_low(2, 40, c);
        checks++;
        if (c > 18) begin
            errors++;
            $display("FAIL starve_bound: I1 completed after %0d cycles, required <= 18", c);
        end
        chk("starve_age_clear", 32'(dut.age_q[1]), 32'd0);
        step();
        dREN = 2'b00;
        iREN[1] = 1'b0;

        // ERROR held for three cycles, then abort by dropping dWEN1
        step();
        lat = 1;
        err = 1'b1;
        daddr[1] = 32'h0000_0900;
        dstore[1] = 32'hDEAD_BEEF;
        dWEN[1] = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge CLK);
            chk("err_ramWEN", 32'(ramWEN), 32'd1);
            chk("err_ramstore", ramstore, 32'hDEAD_BEEF);
            chk("err_dwait1", 32'(dwait[1]), 32'd1);
        end
        step();
        dWEN[1] = 1'b0;
        err = 1'b0;
        @(negedge CLK);
        chk("abort_ramWEN", 32'(ramWEN), 32'd0);
        chk("abort_dwait1", 32'(dwait[1]), 32'd1);
        step();
        dWEN[1] = 1'b1;
        dstore[1] = 32'h1234_5678;
        push(3, 32'h0000_0900, 32'h1234_5678, 1'b1);
        push(3, 32'h0000_0904, 32'h1234_5678, 1'b1);
        @(negedge CLK);
        chk("abort_then_idle", 32'(ramWEN), 32'd0);
        wait_low(3, 10, c);
        step(); daddr[1] = 32'h0000_0904;
        wait_low(3, 10, c);
        step(); dWEN[1] = 1'b0;

        // Write wins over read on the same core
        step();
        lat = 1;
        daddr[0] = 32'h0000_0A00;
        dstore[0] = 32'h0BAD_F00D;
        dREN[0] = 1'b1;
        dWEN[0] = 1'b1;
        push(1, 32'h0000_0A00, 32'h0BAD_F00D, 1'b1);
        push(1, 32'h0000_0A04, 32'h0BAD_F00D, 1'b1);
        wait_low(1, 10, c);
        chk("ww_ramWEN", 32'(ramWEN), 32'd1);
        chk("ww_ramREN", 32'(ramREN), 32'd0);
        step(); daddr[0] = 32'h0000_0A04;
        wait_low(1, 10, c);
        step(); dREN[0] = 1'b0; dWEN[0] = 1'b0;

        // Reset asserted mid-GRANT drops the enables immediately
        step();
        lat = 3;
        iaddr[1] = 32'h0000_00C0;
        iREN[1] = 1'b1;
        step();
        @(negedge CLK);
        chk("mid_ramREN_before", 32'(ramREN), 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("mid_ramREN_async", 32'(ramREN), 32'd0);
        chk("mid_iwait", 32'(iwait), 32'h3);
        iREN[1] = 1'b0;
        step();
        RST = 1'b0;

        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
